// File: rtl/pulse_train_generator.sv
// Pulse train generator.
// Emits num_pulses pulses on dout, each high for high_len cycles and then low
// for low_len cycles, followed by a one-cycle done strobe. The FSM and its
// counters form the first register stage. Every output is a second register
// stage computed from that state, so the outputs lag the state by one edge.
// Abort and reset also act directly on the output registers, so the outputs
// clear on the same edge that samples abort or rst.
module pulse_train_generator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] high_len,
  input  logic [WIDTH-1:0] low_len,
  input  logic [WIDTH-1:0] num_pulses,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] pulses_q, pulses_d;
  logic [WIDTH-1:0] highLen_q, highLen_d;
  logic [WIDTH-1:0] lowLen_q, lowLen_d;
  logic [WIDTH-1:0] numPulses_q, numPulses_d;

  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] pulseCnt_q, pulseCnt_d;

  // State register: FSM, phase/pulse counters, latched train settings and
  // the output registers; reset overrides everything, including start/abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= ZERO;
      pulses_q    <= ZERO;
      highLen_q   <= ONE;
      lowLen_q    <= ONE;
      numPulses_q <= ZERO;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pulseCnt_q  <= ZERO;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pulses_q    <= pulses_d;
      highLen_q   <= highLen_d;
      lowLen_q    <= lowLen_d;
      numPulses_q <= numPulses_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pulseCnt_q  <= pulseCnt_d;
    end
  end

  // Next-state logic. The phase counter counts 0..len-1, so a length of
  // 2^WIDTH-1 fits without wrapping. Zero lengths are stored as 1 when start
  // is accepted. The pulse counter is the number of pulses entered so far.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pulses_d    = pulses_q;
    highLen_d   = highLen_q;
    lowLen_d    = lowLen_q;
    numPulses_d = numPulses_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          highLen_d   = (high_len == ZERO) ? ONE : high_len;
          lowLen_d    = (low_len == ZERO) ? ONE : low_len;
          numPulses_d = num_pulses;
          phase_d     = ZERO;
          if (num_pulses == ZERO) begin
            state_d  = DONE;
            pulses_d = ZERO;
          end else begin
            state_d  = HIGH;
            pulses_d = ONE;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_q == highLen_q - ONE) begin
          state_d = LOW;
          phase_d = ZERO;
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_q == lowLen_q - ONE) begin
          phase_d = ZERO;
          if (pulses_q < numPulses_q) begin
            state_d  = HIGH;
            pulses_d = pulses_q + ONE;
          end else begin
            state_d = DONE;
          end
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. The outputs are derived from the current state, one edge
  // behind it. Abort clears the strobes immediately. pulse_cnt follows the
  // pulse counter only while a train is active, so it keeps its value across
  // an abort and through idle time.
  always_comb begin
    dout_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    pulseCnt_d = pulseCnt_q;
    if (!abort) begin
      case (state_q)
        HIGH: begin
          dout_d     = 1'b1;
          busy_d     = 1'b1;
          pulseCnt_d = pulses_q;
        end
        LOW: begin
          busy_d     = 1'b1;
          pulseCnt_d = pulses_q;
        end
        DONE: begin
          done_d     = 1'b1;
          pulseCnt_d = pulses_q;
        end
        default: begin
          pulseCnt_d = pulseCnt_q;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulseCnt_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Testbench for pulse_train_generator.
// When a train is started, the expected per-edge outputs are pushed into a
// queue. Each edge pops one entry and compares it against the DUT. When the
// queue is empty the DUT is expected to be idle, holding the last count.
module tb_pulse_train_generator;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic             dout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] cnt;
  } expT;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] highLen;
  logic [WIDTH-1:0] lowLen;
  logic [WIDTH-1:0] numPulses;
  logic             dout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] pulseCnt;

  expT              expQ[$];
  logic [WIDTH-1:0] idleCnt;
  int               checkCount = 0;
  int               errorCount = 0;
  int               busyCycles = 0;

  pulse_train_generator #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .high_len   (highLen),
    .low_len    (lowLen),
    .num_pulses (numPulses),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .pulse_cnt  (pulseCnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance one edge, then compare the outputs against the next scoreboard
  // entry, or against the idle state when nothing is pending.
  task automatic tick();
    expT e;
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
    end else begin
      e.dout = 1'b0;
      e.busy = 1'b0;
      e.done = 1'b0;
      e.cnt  = idleCnt;
    end
    if (busy === 1'b1) busyCycles++;
    checkOutput("dout", 32'(dout), 32'(e.dout));
    checkOutput("busy", 32'(busy), 32'(e.busy));
    checkOutput("done", 32'(done), 32'(e.done));
    checkOutput("pulse_cnt", 32'(pulseCnt), 32'(e.cnt));
  endtask

  // Expand a train into the per-edge outputs it should produce after the
  // accepting edge: each pulse is effH high cycles then effL low cycles,
  // followed by one done cycle.
  task automatic pushTrain(input int h, input int l, input int n);
    expT e;
    int  effH;
    int  effL;
    effH = (h == 0) ? 1 : h;
    effL = (l == 0) ? 1 : l;
    for (int p = 1; p <= n; p++) begin
      for (int i = 0; i < effH; i++) begin
        e.dout = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.cnt = WIDTH'(p);
        expQ.push_back(e);
      end
      for (int i = 0; i < effL; i++) begin
        e.dout = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.cnt = WIDTH'(p);
        expQ.push_back(e);
      end
    end
    e.dout = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.cnt = WIDTH'(n);
    expQ.push_back(e);
    idleCnt = WIDTH'(n);
  endtask

  // Drive one start pulse with the given fields, then scramble the fields
  // so that later changes must not affect the running train.
  task automatic applyStimulus(input int h, input int l, input int n);
    highLen   = WIDTH'(h);
    lowLen    = WIDTH'(l);
    numPulses = WIDTH'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    pushTrain(h, l, n);
    highLen   = WIDTH'($urandom_range(1, 200));
    lowLen    = WIDTH'($urandom_range(1, 200));
    numPulses = WIDTH'($urandom_range(1, 200));
  endtask

  // Run until the scoreboard is empty, within a fixed cycle budget.
  task automatic drain();
    int budget = 2000;
    while (expQ.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
    tick();
    tick();
  endtask

  // Complete train, including the total busy time.
  task automatic runTrain(input int h, input int l, input int n);
    int effH;
    int effL;
    effH = (h == 0) ? 1 : h;
    effL = (l == 0) ? 1 : l;
    busyCycles = 0;
    applyStimulus(h, l, n);
    drain();
    checkOutput("busy_time", 32'(busyCycles), 32'(n * (effH + effL)));
  endtask

  // Abort on the next edge: outputs clear there and pulse_cnt keeps the
  // value it showed on the previous edge.
  task automatic doAbort(input logic [WIDTH-1:0] heldCnt);
    expQ.delete();
    idleCnt = heldCnt;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
  endtask

  // Main sequence.
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    highLen   = '0;
    lowLen    = '0;
    numPulses = '0;
    idleCnt   = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("[TB] basic train 2/3/3");
    runTrain(2, 3, 3);

    $display("[TB] zero lengths and zero pulses");
    runTrain(0, 0, 2);
    runTrain(0, 0, 0);

    $display("[TB] start while busy");
    busyCycles = 0;
    applyStimulus(3, 2, 2);
    tick();
    tick();
    highLen   = 8'd7;
    lowLen    = 8'd9;
    numPulses = 8'd5;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    drain();
    checkOutput("busy_time_restart", 32'(busyCycles), 32'd10);

    $display("[TB] abort mid-LOW of pulse 2");
    applyStimulus(2, 4, 3);
    for (int i = 0; i < 9; i++) tick();
    doAbort(8'd2);
    for (int i = 0; i < 4; i++) tick();
    runTrain(1, 1, 2);

    $display("[TB] abort and start together in IDLE");
    highLen   = 8'd2;
    lowLen    = 8'd2;
    numPulses = 8'd2;
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start     = 1'b0;
    abort     = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("[TB] reset mid-HIGH with start");
    applyStimulus(5, 2, 2);
    tick();
    tick();
    expQ.delete();
    idleCnt   = '0;
    highLen   = 8'd3;
    lowLen    = 8'd3;
    numPulses = 8'd3;
    rst       = 1'b1;
    start     = 1'b1;
    tick();
    rst       = 1'b0;
    start     = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    runTrain(3, 1, 1);

    $display("[TB] maximum lengths");
    runTrain(255, 255, 1);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the width of the length and count fields.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, request to begin a pulse train, sampled on each clk edge.
REQ-005 SHALL have port abort, input, 1 bit, request to terminate the current train.
REQ-006 SHALL have port high_len, input, WIDTH bits, number of cycles dout is high per pulse.
REQ-007 SHALL have port low_len, input, WIDTH bits, number of cycles dout is low after each pulse.
REQ-008 SHALL have port num_pulses, input, WIDTH bits, number of pulses in the train.
REQ-009 SHALL have port dout, output, 1 bit, the registered generated waveform.
REQ-010 SHALL have port busy, output, 1 bit, high while a train is in progress.
REQ-011 SHALL have port done, output, 1 bit, a one-cycle strobe when a train completes normally.
REQ-012 SHALL have port pulse_cnt, output, WIDTH bits, count of rising edges emitted on dout in the current or last train.

Function
REQ-013 SHALL implement states IDLE, HIGH, LOW and DONE.
REQ-014 SHALL make every output a registered value driven from the state and counters, with no combinational path from input to output.
REQ-015 SHALL latch high_len, low_len and num_pulses when start is accepted, and SHALL ignore later changes to them until the next accept.
REQ-016 SHALL accept start only in IDLE, and SHALL ignore start in every other state.
REQ-017 SHALL treat high_len=0 as 1 and low_len=0 as 1.
REQ-018 SHALL, on an accepted start with num_pulses=0, go IDLE->DONE, with dout and busy staying 0 and pulse_cnt cleared to 0.
REQ-019 SHALL, on an accepted start at edge k with num_pulses>0, set dout=1, busy=1 and pulse_cnt=1 from edge k+1.
REQ-020 SHALL, in HIGH, hold dout=1 for exactly high_len cycles, then go to LOW.
REQ-021 SHALL, in LOW, hold dout=0 for exactly low_len cycles.
REQ-022 SHALL, at the end of LOW with fewer than num_pulses pulses emitted, go to HIGH and increment pulse_cnt on the same edge dout rises.
REQ-023 SHALL, at the end of the last LOW phase, go to DONE; the final low phase is always fully emitted.
REQ-024 SHALL, in DONE, drive done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-025 SHALL, on abort in HIGH, LOW or DONE, go to IDLE on the next edge with dout=0, busy=0 and done=0; pulse_cnt holds its value.
REQ-026 SHALL give abort priority when abort and start are both asserted in IDLE; no train starts.
REQ-027 SHALL run counters modulo nothing: lengths up to 2^WIDTH-1 cycles are supported exactly, without wrap.
REQ-028 SHALL keep the pulse_cnt reached at the end of a train until the next accepted start.
REQ-029 SHALL produce a period of (high_len + low_len) cycles per pulse and a total busy time of num_pulses*(high_len + low_len) cycles.

Reset
REQ-030 SHALL, when rst=1 at a clk edge, set state IDLE, dout=0, busy=0, done=0 and pulse_cnt=0, regardless of state, including mid-train.
REQ-031 SHALL give rst priority over start and abort.
REQ-032 SHALL ignore start sampled in the same cycle as rst=1.

Verification
REQ-033 SHALL cover a basic train: high_len=2, low_len=3, num_pulses=3, start at edge 10 -> dout=1 at edges 11-12, 16-17 and 21-22; busy=1 at edges 11-25; done=1 at edge 26 only; pulse_cnt ends at 3.
REQ-034 SHALL cover zero fields: high_len=0, low_len=0, num_pulses=2 -> dout pattern 1,0,1,0, then done; num_pulses=0 -> done one cycle after start, with dout never high.
REQ-035 SHALL cover start while busy: a second start with different lengths during HIGH -> the waveform is unchanged and a single done strobe occurs.
REQ-036 SHALL cover abort mid-LOW of pulse 2 -> dout=0 and busy=0 on the next edge, no done, pulse_cnt=2; a new start is then accepted normally.
REQ-037 SHALL cover reset mid-HIGH: rst=1 for one edge -> all outputs 0 on that edge, and start in the same cycle is ignored.
REQ-038 SHALL cover maximum lengths: high_len=low_len=255, num_pulses=1 -> dout high for exactly 255 cycles, low for 255 cycles, then done.
